// File: rtl/uart_tx_fifo_if.sv
// Write-side handshake and status bundle of the FIFO-fed UART transmitter.
// The bench or host drives the master side; the transmitter uses the slave side.
interface uart_tx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
);
  logic                         enable;
  logic [DATA_WIDTH-1:0]        i_data;
  logic                         o_full;
  logic                         o_overflow;
  logic [$clog2(DEPTH+1)-1:0]   o_level;
  logic                         o_busy;
  logic                         serial_out;

  modport master (
    output enable, i_data,
    input  o_full, o_overflow, o_level, o_busy, serial_out
  );

  modport slave (
    input  enable, i_data,
    output o_full, o_overflow, o_level, o_busy, serial_out
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a DEPTH-entry FIFO; frames are start, data LSB first,
// optional parity, then stop bits. Queued words leave back-to-back.
//
//  state | meaning
//  IDLE  | line held high, waiting for a queued word
//  SHIFT | a frame is on the line, one bit per CLOCKS_PER_BIT cycles
module uart_tx_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY_MODE    = 1,
  parameter int STOP_BITS      = 1,
  parameter int CLOCKS_PER_BIT = 8,
  parameter int DEPTH          = 4
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_fifo_if.slave  bus
);
  localparam int NBITS = 1 + DATA_WIDTH + ((PARITY_MODE != 0) ? 1 : 0) + STOP_BITS;
  localparam int CW    = $clog2(CLOCKS_PER_BIT);
  localparam int BCW   = $clog2(NBITS);
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  line;
  logic [NBITS-2:0]      shreg;
  logic [CW-1:0]         baud_cnt;
  logic [BCW-1:0]        bit_cnt;

  logic                  full;
  logic                  have_word;
  logic                  push;
  logic                  pop;
  logic                  baud_tc;
  logic                  last_bit;
  logic [NBITS-1:0]      frame_next;

  function automatic logic [NBITS-1:0] build_frame(input logic [DATA_WIDTH-1:0] d);
    logic [NBITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    f[DATA_WIDTH:1] = d;
    if (PARITY_MODE == 1)
      f[DATA_WIDTH+1] = ^d;
    else if (PARITY_MODE == 2)
      f[DATA_WIDTH+1] = ~^d;
    return f;
  endfunction

  assign full       = (level == LW'(DEPTH));
  assign have_word  = (level != '0);
  assign push       = bus.enable && !full;
  assign baud_tc    = (baud_cnt == CW'(CLOCKS_PER_BIT - 1));
  assign last_bit   = (bit_cnt == BCW'(NBITS - 1));
  // Pop either from idle or on the final edge of the last stop bit, so
  // consecutive frames have no idle cycle between them.
  assign pop        = have_word && ((state == IDLE) || (baud_tc && last_bit));
  assign frame_next = build_frame(mem[rd_ptr]);

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= bus.enable && full;
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      line     <= 1'b1;
      shreg    <= '1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          line <= 1'b1;
          if (pop) begin
            line     <= frame_next[0];
            shreg    <= frame_next[NBITS-1:1];
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (last_bit) begin
              if (pop) begin
                line    <= frame_next[0];
                shreg   <= frame_next[NBITS-1:1];
                bit_cnt <= '0;
              end else begin
                line  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              line    <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_full     = full;
  assign bus.o_overflow = overflow;
  assign bus.o_level    = level;
  assign bus.o_busy     = (state == SHIFT) || have_word;
  assign bus.serial_out = line;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue/countdown reference model checks FIFO status
// each cycle; line monitors decode frames and match them against a scoreboard.
module tb_uart_tx_fifo;
  localparam int DW_A = 8, PM_A = 1, SB_A = 1, CPB_A = 8, DEPTH_A = 4;
  localparam int NB_A = 1 + DW_A + 1 + SB_A;
  localparam int DW_B = 7, PM_B = 2, SB_B = 2, CPB_B = 4, DEPTH_B = 2;
  localparam int NB_B = 1 + DW_B + 1 + SB_B;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_WIDTH(DW_A), .DEPTH(DEPTH_A)) bus_a ();
  uart_tx_fifo_if #(.DATA_WIDTH(DW_B), .DEPTH(DEPTH_B)) bus_b ();

  uart_tx_fifo #(.DATA_WIDTH(DW_A), .PARITY_MODE(PM_A), .STOP_BITS(SB_A),
                 .CLOCKS_PER_BIT(CPB_A), .DEPTH(DEPTH_A))
    dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  uart_tx_fifo #(.DATA_WIDTH(DW_B), .PARITY_MODE(PM_B), .STOP_BITS(SB_B),
                 .CLOCKS_PER_BIT(CPB_B), .DEPTH(DEPTH_B))
    dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  typedef struct {
    logic [8:0] data;
    int         start;
  } exp_t;

  exp_t       exp_a[$];
  exp_t       exp_b[$];
  logic [7:0] mq[$];
  int         rem = 0;
  int         b_free = 0;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         epoch = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)",
               name, cyc, act, act, exp, exp);
    end
  endfunction

  // Expected line bits of one frame, straight from the frame rules.
  function automatic logic [15:0] ref_frame(input logic [8:0] d, input int dw,
                                            input int pm);
    logic [15:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < dw; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (pm == 1)      f[1+dw] = ((ones % 2) == 1);
    else if (pm == 2) f[1+dw] = ((ones % 2) == 0);
    return f;
  endfunction

  function automatic logic sline(input int inst);
    return (inst == 0) ? bus_a.serial_out : bus_b.serial_out;
  endfunction

  task automatic tick(input bit rst, input bit en_a, input logic [7:0] d_a,
                      input bit en_b, input logic [6:0] d_b);
    bit         exp_ovf;
    bit         was_full;
    int         pre;
    logic [7:0] w;
    reset        = rst;
    bus_a.enable = en_a;
    bus_a.i_data = d_a;
    bus_b.enable = en_b;
    bus_b.i_data = d_b;
    @(posedge clk);
    cyc++;
    exp_ovf = 1'b0;
    if (rst) begin
      mq.delete();
      exp_a.delete();
      exp_b.delete();
      rem    = 0;
      b_free = 0;
      epoch++;
    end else begin
      pre      = mq.size();
      was_full = (pre == DEPTH_A);
      if (rem <= 1 && pre > 0) begin
        w = mq.pop_front();
        exp_a.push_back('{{1'b0, w}, cyc});
        rem = NB_A * CPB_A;
      end else if (rem > 0) begin
        rem--;
      end
      if (en_a) begin
        if (was_full) exp_ovf = 1'b1;
        else          mq.push_back(d_a);
      end
      if (en_b) begin
        exp_b.push_back('{{2'b00, d_b}, cyc + 1});
        b_free = cyc + 1 + NB_B * CPB_B;
      end
    end
    #1;
    chk("level", int'(bus_a.o_level), mq.size());
    chk("full", int'(bus_a.o_full), int'(mq.size() == DEPTH_A));
    chk("overflow", int'(bus_a.o_overflow), int'(exp_ovf));
    chk("busy", int'(bus_a.o_busy), int'(rem > 0 || mq.size() > 0));
    if (rem == 0) chk("idle_line", int'(bus_a.serial_out), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 7'h00);
  endtask

  task automatic mon(input int inst);
    int          cpb, nb, dw, pm, st, ep;
    logic [15:0] bits;
    logic [15:0] rf;
    logic        v;
    bit          stable, aborted, empty;
    exp_t        e;
    cpb = (inst == 0) ? CPB_A : CPB_B;
    nb  = (inst == 0) ? NB_A  : NB_B;
    dw  = (inst == 0) ? DW_A  : DW_B;
    pm  = (inst == 0) ? PM_A  : PM_B;
    forever begin
      @(negedge clk);
      if (sline(inst) === 1'b0) begin
        st      = cyc;
        ep      = epoch;
        bits    = '1;
        stable  = 1'b1;
        aborted = 1'b0;
        for (int c = 0; c < nb * cpb; c++) begin
          if (c > 0) @(negedge clk);
          if (epoch != ep) begin
            aborted = 1'b1;
            break;
          end
          v = sline(inst);
          if (c % cpb == 0)             bits[c/cpb] = v;
          else if (v !== bits[c/cpb])   stable = 1'b0;
        end
        if (!aborted) begin
          empty = (inst == 0) ? (exp_a.size() == 0) : (exp_b.size() == 0);
          if (empty) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame dut%0d at cycle %0d: got bits 0x%0h expected no frame",
                     inst, st, bits);
          end else begin
            e  = (inst == 0) ? exp_a.pop_front() : exp_b.pop_front();
            rf = ref_frame(e.data, dw, pm);
            chk((inst == 0) ? "frame_a" : "frame_b", int'(bits), int'(rf));
            chk((inst == 0) ? "start_a" : "start_b", st, e.start);
            chk((inst == 0) ? "bit_hold_a" : "bit_hold_b", int'(stable), 1);
          end
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    int  n;
    bit  en_a, en_b;
    int  prob;
    reset        = 1'b1;
    bus_a.enable = 1'b0;
    bus_a.i_data = '0;
    bus_b.enable = 1'b0;
    bus_b.i_data = '0;

    repeat (3) tick(1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
    chk("reset_line", int'(bus_a.serial_out), 1);
    idle(2);

    // 0xA5 on the default build, 0x00 on the odd-parity build.
    tick(1'b0, 1'b1, 8'hA5, 1'b1, 7'h00);
    tick(1'b0, 1'b0, 8'h00, 1'b0, 7'h00);
    chk("start_low", int'(bus_a.serial_out), 0);
    n = 0;
    while (bus_a.o_busy && n < 200) begin
      tick(1'b0, 1'b0, 8'h00, 1'b0, 7'h00);
      n++;
    end
    chk("busy_frame_len", n, NB_A * CPB_A);
    idle(20);

    // six back-to-back writes: the sixth overflows
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 8'($urandom), 1'b0, 7'h00);
    idle(5 * NB_A * CPB_A + 20);

    for (int i = 0; i < 1600; i++) begin
      prob = ((i / 200) % 2 == 1) ? 2 : 8;
      en_a = ($urandom_range(0, prob - 1) == 0);
      en_b = ((cyc + 1) >= b_free) && ($urandom_range(0, 2) == 0);
      tick(1'b0, en_a, 8'($urandom), en_b, 7'($urandom));
    end
    idle(DEPTH_A * NB_A * CPB_A + 150);

    // three queued words, reset during data bit 3 of the first frame
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'($urandom), 1'b0, 7'h00);
    idle(34);
    tick(1'b1, 1'b0, 8'h00, 1'b0, 7'h00);
    chk("abort_line", int'(bus_a.serial_out), 1);
    chk("abort_level", int'(bus_a.o_level), 0);
    chk("abort_busy", int'(bus_a.o_busy), 0);
    idle(300);

    chk("pending_a", exp_a.size(), 0);
    chk("pending_b", exp_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
